multiplicador_datapath: RTL and testbench
=========================================

Name: multiplicador_datapath

Overview:
- Shift-and-add multiplier datapath driven by the hardwired control unit's strobes (CargaQ, DesplazaQ, ResetA, CargaA, Fin).
- Returns q0, the LSB of Q, to the control unit so it can decide whether to add.
- Holds registers M (multiplicand), Q (multiplier/low product), A (high product) and carry C.
- On Fin, captures the 2N-bit product into an output register and presents it with a valid/ack handshake to the consumer.

Parameters:
N  4  operand width in bits; product width is 2N.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
multiplicando  input  N  operand loaded into M on CargaQ
multiplicador  input  N  operand loaded into Q on CargaQ
CargaQ  input  1  load M and Q from operand inputs
DesplazaQ  input  1  shift {C,A,Q} right by one
ResetA  input  1  clear A and C
CargaA  input  1  {C,A} <= A + M
Fin  input  1  capture {A,Q} into producto, raise valido
ack  input  1  consumer acknowledges producto
q0  output  1  Q[0], combinational from register Q
producto  output  2N  registered product
valido  output  1  producto holds an unacknowledged result
err  output  1  sticky: illegal strobe combination seen

Behaviour:
- Reset (sync, high, priority over everything): M, Q, A, C, producto = 0; valido = 0; err = 0. q0 = 0 follows.
- All strobes act at the rising edge where they are high. Effects are visible on the next cycle; latency is 1 clock per strobe.
- CargaQ: M <= multiplicando, Q <= multiplicador.
- ResetA: A <= 0, C <= 0.
- CargaQ and ResetA together: both apply in the same edge. This is the normal S0 case.
- CargaA: {C,A} <= zero-extended A + zero-extended M, computed N+1 bits wide with no overflow loss.
- DesplazaQ: Q <= {A[0], Q[N-1:1]}, A <= {C, A[N-1:1]}, C <= 0 (logical right shift of the concatenation C,A,Q).
- CargaA and DesplazaQ together (illegal):
  - Shift is performed on the pre-add values and the add is discarded.
  - err <= 1, sticky until reset.
- CargaA together with CargaQ or ResetA (illegal):
  - CargaQ/ResetA effects apply; the add is discarded.
  - err <= 1.
- No strobe high: all working registers hold.
- Fin:
  - producto <= {A,Q} (current register values, before any same-edge update) and valido <= 1.
  - Fin does not alter A, Q, M or C.
- Handshake:
  - valido stays 1 and producto stays stable until a rising edge with ack = 1 and valido = 1; valido then <= 0.
  - ack while valido = 0 is ignored.
  - Fin and ack on the same edge: the new capture wins, valido stays 1 and producto updates.
  - Fin while valido = 1 and ack = 0: overwrite producto, valido stays 1. Unconsumed data is lost, which is not an error.
- Reset mid-multiplication or mid-handshake: all state cleared next edge. The control unit is restarted separately via start.
- Sequence for a full multiply:
  - One CargaQ+ResetA cycle.
  - N iterations of (CargaA if q0) then DesplazaQ.
  - Then Fin. The result is exact for all operand pairs, since max product (2^N-1)^2 < 2^2N.

Test Plan:
- Reset: assert reset 2 cycles with random strobes -> producto=0x00, valido=0, err=0, q0=0.
- N=4, 13*11:
  - CargaQ+ResetA with multiplicando=0xD, multiplicador=0xB, then 4 add/shift iterations gated by q0, then Fin.
  - Required: producto=0x8F and valido=1 one cycle after Fin.
- 15*15 (carry path exercised every iteration) -> producto=0xE1.
- 0*9 -> producto=0x00.
- After 15*15, q0 sequence during iterations is 1,1,1,1.
- Handshake:
  - Hold ack=0 for 5 cycles after Fin -> valido=1, producto stable.
  - Assert ack 1 cycle -> valido=0 next cycle.
  - Fin+ack same edge -> valido stays 1, producto = new value.
- Illegal strobes:
  - With A=0x3, M=0x5, C=0, pulse CargaA and DesplazaQ together -> A=0x1 (shift only, no add), err=1.
  - err holds through later strobes until reset.
  - Reset mid-iteration -> A=Q=M=0 next cycle.

Source files
------------

// File: rtl/multiplicador_datapath.sv
// multiplicador_datapath: shift-and-add multiplier datapath with valid/ack product output
module multiplicador_datapath #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  input  logic           CargaQ,
  input  logic           DesplazaQ,
  input  logic           ResetA,
  input  logic           CargaA,
  input  logic           Fin,
  input  logic           ack,
  output logic           q0,
  output logic [2*N-1:0] producto,
  output logic           valido,
  output logic           err
);
  logic [N-1:0]   m_q, m_d, q_q, q_d, a_q, a_d;
  logic           c_q, c_d, v_q, v_d, e_q, e_d, illegal;
  logic [2*N-1:0] p_q, p_d;
  logic [N:0]     sum;
  always_comb begin
    illegal = CargaA & (DesplazaQ | CargaQ | ResetA);
    sum     = {1'b0, a_q} + {1'b0, m_q};
    m_d     = CargaQ ? multiplicando : m_q;
    q_d     = CargaQ ? multiplicador : DesplazaQ ? {a_q[0], q_q[N-1:1]} : q_q;
    // a shift takes precedence over an add, so a conflicting add is simply dropped
    {c_d, a_d} = ResetA ? '0 : DesplazaQ ? {1'b0, c_q, a_q[N-1:1]} :
                 (CargaA & ~illegal) ? sum : {c_q, a_q};
    p_d     = Fin ? {a_q, q_q} : p_q;
    v_d     = Fin | (v_q & ~ack);
    e_d     = e_q | illegal;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      q_q <= '0;
      a_q <= '0;
      c_q <= 1'b0;
      p_q <= '0;
      v_q <= 1'b0;
      e_q <= 1'b0;
    end else begin
      m_q <= m_d;
      q_q <= q_d;
      a_q <= a_d;
      c_q <= c_d;
      p_q <= p_d;
      v_q <= v_d;
      e_q <= e_d;
    end
  end
  assign q0       = q_q[0];
  assign producto = p_q;
  assign valido   = v_q;
  assign err      = e_q;
endmodule

// File: tb/tb_multiplicador_datapath.sv
// tb_multiplicador_datapath: randomized check against a register-level arithmetic model
module tb_multiplicador_datapath;
  localparam int N = 4;
  localparam int W = 2 * N;
  logic clk = 0, reset = 0;
  logic [N-1:0] multiplicando = 0, multiplicador = 0;
  logic CargaQ = 0, DesplazaQ = 0, ResetA = 0, CargaA = 0, Fin = 0, ack = 0;
  logic q0, valido, err;
  logic [W-1:0] producto;
  int tests = 0, fails = 0;
  int mA = 0, mQ = 0, mM = 0, mC = 0, mP = 0, mV = 0, mE = 0;

  multiplicador_datapath #(.N(N)) dut (
    .clk(clk), .reset(reset), .multiplicando(multiplicando), .multiplicador(multiplicador),
    .CargaQ(CargaQ), .DesplazaQ(DesplazaQ), .ResetA(ResetA), .CargaA(CargaA), .Fin(Fin),
    .ack(ack), .q0(q0), .producto(producto), .valido(valido), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, cq, ra, ca, dq, fn, ak, input int md, input int mr);
    int v, nA, nQ, nM, nC;
    bit ill;
    reset = r; CargaQ = cq; ResetA = ra; CargaA = ca; DesplazaQ = dq; Fin = fn; ack = ak;
    multiplicando = md[N-1:0]; multiplicador = mr[N-1:0];
    @(posedge clk);
    if (r) begin
      mA = 0; mQ = 0; mM = 0; mC = 0; mP = 0; mV = 0; mE = 0;
    end else begin
      ill = ca && (dq || cq || ra);
      nA = mA; nQ = mQ; nM = mM; nC = mC;
      if (dq) begin
        v  = ((mC << W) | (mA << N) | mQ) >> 1;
        nQ = v % (1 << N); nA = (v >> N) % (1 << N); nC = v >> W;
      end else if (ca && !ill) begin
        v = mA + mM; nA = v % (1 << N); nC = v >> N;
      end
      if (ra) begin nA = 0; nC = 0; end
      if (cq) begin nM = md % (1 << N); nQ = mr % (1 << N); end
      if (fn) begin mP = mA * (1 << N) + mQ; mV = 1; end
      else if (ak) mV = 0;
      if (ill) mE = 1;
      mA = nA; mQ = nQ; mM = nM; mC = nC;
    end
    #1;
    chk("q0", q0, mQ & 1);
    chk("producto", producto, mP);
    chk("valido", valido, mV);
    chk("err", err, mE);
  endtask

  task automatic idle(input bit ak);
    step(0, 0, 0, 0, 0, 0, ak, 0, 0);
  endtask

  task automatic mult(input int a, input int b, input bit ak, input bit q0_ones);
    step(0, 1, 1, 0, 0, 0, 0, a, b);
    for (int i = 0; i < N; i++) begin
      if (q0_ones) chk("q0_seq", q0, 1);
      if (q0) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 1, ak, 0, 0);
    chk("product", producto, a * b);
    chk("prod_valid", valido, 1);
  endtask

  initial begin
    int p;
    for (int i = 0; i < 2; i++) begin
      p = $urandom;
      step(1, p[0], p[1], p[2], p[3], p[4], p[5], p[11:8], p[15:12]);
    end
    chk("rst_prod", producto, 0);
    chk("rst_valid", valido, 0);
    chk("rst_err", err, 0);
    chk("rst_q0", q0, 0);
    mult(13, 11, 0, 0);
    chk("13x11", producto, 'h8F);
    mult(15, 15, 0, 1);
    chk("15x15", producto, 'hE1);
    p = producto;
    for (int i = 0; i < 5; i++) begin
      idle(0);
      chk("hold_valid", valido, 1);
      chk("hold_prod", producto, p);
    end
    idle(1);
    chk("ack_clear", valido, 0);
    idle(1);
    chk("ack_ignored", valido, 0);
    mult(0, 9, 0, 0);
    chk("0x9", producto, 0);
    mult(7, 6, 1, 0);
    chk("fin_ack_valid", valido, 1);
    chk("fin_ack_prod", producto, 42);
    for (int i = 0; i < 30; i++) begin
      p = $urandom;
      mult(p[3:0], p[7:4], p[8], 0);
      if (p[9]) idle(1);
    end
    // build A=3, M=5, C=0, then a conflicting add+shift
    step(0, 1, 1, 0, 0, 0, 0, 3, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 5, 6);
    chk("err_before", err, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("ill_err", err, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("ill_A", producto[W-1:N], 1);
    chk("ill_Q", producto[N-1:0], 'hB);
    mult(3, 4, 1, 0);
    chk("err_sticky", err, 1);
    step(0, 1, 1, 1, 0, 0, 0, 9, 9);
    chk("ill_load_err", err, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("ill_load_A", producto[W-1:N], 0);
    step(0, 1, 1, 0, 0, 0, 0, 13, 11);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_err", err, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("mid_rst_prod", producto, 0);
    for (int i = 0; i < 300; i++) begin
      p = $urandom;
      step(p[31:26] == 0, p[0] & p[1], p[2] & p[3], p[4], p[5], p[6] & p[7], p[8], p[15:12], p[19:16]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
